pwm_multi_core: RTL
===================

# pwm_multi_core

Multi-channel, parametrised successor to the single-channel PWM core. It drives CH PWM channels from one shared period counter, with edge-aligned and center-aligned counting. Duty, period and mode updates are double-buffered so they take effect only at a period boundary, which keeps output pulses glitch-free. Complementary outputs with optional dead-time insertion feed gate drivers; the block sits between the register/switch front end and the output pins and scope header.

## Interface
- N, 10, counter/period/duty width in bits
- CH, 4, number of PWM channels
- DT_W, 6, dead-time counter width in bits
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low
- enable  in  1  run counter; 0 holds counter at 1 and forces all outputs low
- period  in  N  period in clk cycles (staged)
- duty  in  CH*N  per-channel duty; channel k is bits [k*N +: N] (staged)
- mode  in  1  0 = edge-aligned, 1 = center-aligned (staged)
- dead_time  in  DT_W  dead-time in cycles (staged; ignored without PWM_DEADTIME_EN)
- load_req  in  1  one-cycle pulse; captures period/duty/mode/dead_time into staging
- load_pending  out  1  staging holds values not yet applied
- load_done  out  1  one-cycle pulse when staging is copied to the active registers
- period_tick  out  1  one-cycle pulse at each period boundary
- pwm_out  out  CH  true outputs
- pwm_out_n  out  CH  complementary outputs

## Operation
- **Reset:**
  - counter = 1 and dir = up.
  - All active and staging registers = 0.
  - load_pending = 0.
  - load_done, period_tick, pwm_out and pwm_out_n all = 0.
- **Edge-aligned mode:** the counter runs 1..P_act, then wraps to 1. The boundary is the cycle in which counter == P_act.
- **Center-aligned mode:**
  - Counts up 1..P_act, then down P_act-1..1.
  - dir flips at P_act and at 1.
  - The boundary is the cycle in which counter == 1 and dir == down, or the first counting cycle after enable rises.
- **P_act clamping:** P_act = 0 or 1 is treated as 1. The counter holds at 1 and every cycle is a boundary.
- **Channel compare:** channel k is high iff counter <= D_act[k].
  - D_act[k] = 0 gives constant low.
  - D_act[k] >= P_act gives constant high.
- **Staging:**
  - load_req copies the inputs into staging and sets load_pending.
  - A second load_req while pending overwrites staging. Only one load_done follows.
- **Apply:**
  - At a boundary with load_pending = 1, staging is copied to active, load_done pulses and load_pending clears.
  - The new values govern the cycle after the boundary.
  - While enable = 0, apply happens on the cycle after load_req.
- **load_req coinciding with a boundary:** the request is staged and is applied at the next boundary, not the current one.
- **Mode change at apply:** the counter restarts at 1 with dir = up.
- **enable falling:** the counter is forced to 1 with dir = up, and outputs go low on the next cycle.
- **Counter width:** the counter is N bits and never exceeds P_act, so it cannot overflow.

## Timing
- pwm_out[k] is registered: its value in cycle t+1 reflects the counter compare in cycle t. The latency is 1 cycle.
- period_tick and load_done are registered and assert in the cycle after the boundary.
- Without dead-time insertion, pwm_out_n = ~pwm_out while enable = 1, and 0 while disabled. Both are registered in the same cycle.
- Dead-time insertion, when compiled in, adds no latency to falling edges. Each rising edge is delayed by DT_act cycles.
- An asynchronous reset mid-period aborts the cycle immediately and discards staging.

## Configuration
- **PWM_DEADTIME_EN defined:**
  - Each channel has a dead-time counter.
  - A rising edge on pwm_out[k] or pwm_out_n[k] is delayed until DT_act cycles have elapsed since the opposite output fell.
  - A pulse shorter than DT_act is suppressed entirely.
  - pwm_out[k] and pwm_out_n[k] are never high together.
  - DT_act = 0 behaves identically to the macro being undefined.
- **PWM_DEADTIME_EN undefined:** pwm_out_n is the plain complement described above. The dead_time port is present but unused.

## Test plan
- Edge mode, P=10, D={0,3,10,15}, load_req with enable=0, then enable=1 → ch0 constantly low; ch1 high 3 of every 10 cycles; ch2 and ch3 constantly high; period_tick every 10 cycles.
- Mid-period load_req with D[1]=7 at counter=4 → old duty 3 completes the current period; load_done one cycle after counter==10; next period high for 7 cycles.
- Center mode, P=8, D[0]=4 → period_tick every 14 cycles; ch0 high for counter<=4 on both up and down slopes (7 cycles per period, centered).
- Two load_reqs (D=2, then D=5) within one period → single load_done; active D = 5.
- PWM_DEADTIME_EN, P=20, D=10, DT=3 → 3-cycle gap where both outputs are low after each edge; D=2 with DT=3 → pwm_out suppressed, never overlapping pwm_out_n.
- Reset asserted at counter=6 with load_pending=1 → all outputs 0 immediately; after release, counter=1 and load_pending=0.

Source files
------------

// File: rtl/pwm_multi_core.sv
// pwm_multi_core: CH-channel PWM on one shared edge/center-aligned period counter with
// double-buffered period/duty/mode. Define PWM_DEADTIME_EN to add per-channel dead-time insertion.
module pwm_multi_core #(
    parameter int N    = 10,
    parameter int CH   = 4,
    parameter int DT_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic [N-1:0]    period,
    input  logic [CH*N-1:0] duty,
    input  logic            mode,
    input  logic [DT_W-1:0] dead_time,
    input  logic            load_req,
    output logic            load_pending,
    output logic            load_done,
    output logic            period_tick,
    output logic [CH-1:0]   pwm_out,
    output logic [CH-1:0]   pwm_out_n
);

    // state | meaning
    // UP    | counter incrementing (edge mode, or rising half of center mode)
    // DOWN  | counter decrementing (falling half of center mode)
    typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_t;

    localparam logic [N-1:0] ONE = N'(1);
    localparam logic [N-1:0] TWO = N'(2);

    dir_t            dir, dir_nx;
    logic [N-1:0]    cnt, cnt_nx;
    logic [N-1:0]    p_act, p_stg, p_eff, p_new_eff;
    logic [CH*N-1:0] d_act, d_stg;
    logic            mode_act, mode_stg;
    logic            en_prev;
    logic            boundary, apply;
    logic [CH-1:0]   cmp, hi_nx, lo_nx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= ONE;
            dir     <= UP;
            en_prev <= 1'b0;
        end else begin
            cnt     <= cnt_nx;
            dir     <= dir_nx;
            en_prev <= enable;
        end
    end

    always_comb begin
        boundary  = 1'b0;
        apply     = 1'b0;
        cnt_nx    = cnt;
        dir_nx    = dir;
        p_eff     = (p_act > ONE) ? p_act : ONE;
        p_new_eff = p_eff;

        // Periods of 0 or 1 collapse to a counter parked at 1 with a boundary every cycle.
        if (p_eff == ONE)
            boundary = 1'b1;
        else if (mode_act)
            boundary = (cnt == ONE && dir == DOWN) || !en_prev;
        else
            boundary = (cnt == p_eff);

        apply = load_pending && (!enable || boundary);
        if (apply)
            p_new_eff = (p_stg > ONE) ? p_stg : ONE;

        if (!enable || (apply && mode_stg != mode_act)) begin
            cnt_nx = ONE;
            dir_nx = UP;
        end else if (boundary) begin
            cnt_nx = (mode_act && p_new_eff != ONE) ? TWO : ONE;
            dir_nx = UP;
        end else if (!mode_act) begin
            cnt_nx = cnt + ONE;
        end else if (dir == UP) begin
            if (cnt >= p_eff) begin
                cnt_nx = cnt - ONE;
                dir_nx = DOWN;
            end else begin
                cnt_nx = cnt + ONE;
            end
        end else begin
            cnt_nx = cnt - ONE;
        end
    end

    always_comb begin
        cmp = '0;
        for (int k = 0; k < CH; k++)
            cmp[k] = (cnt <= d_act[k*N +: N]);
    end

    // Staging captures on load_req; apply always copies the staging seen before this cycle's request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p_act        <= '0;
            p_stg        <= '0;
            d_act        <= '0;
            d_stg        <= '0;
            mode_act     <= 1'b0;
            mode_stg     <= 1'b0;
            load_pending <= 1'b0;
            load_done    <= 1'b0;
            period_tick  <= 1'b0;
            pwm_out      <= '0;
            pwm_out_n    <= '0;
        end else begin
            if (load_req) begin
                p_stg    <= period;
                d_stg    <= duty;
                mode_stg <= mode;
            end
            if (apply) begin
                p_act    <= p_stg;
                d_act    <= d_stg;
                mode_act <= mode_stg;
            end
            load_pending <= load_req || (load_pending && !apply);
            load_done    <= apply;
            period_tick  <= enable && boundary;
            pwm_out      <= hi_nx;
            pwm_out_n    <= lo_nx;
        end
    end

`ifdef PWM_DEADTIME_EN
    localparam logic [DT_W-1:0] DT_ONE = DT_W'(1);
    localparam logic [DT_W-1:0] DT_MAX = '1;

    logic [DT_W-1:0] dt_act, dt_stg;
    logic [CH-1:0]   cmp_q;
    logic [DT_W-1:0] stab [CH];
    logic [DT_W-1:0] run  [CH];

    // run = cycles the compare result has held its current value before this one.
    always_comb begin
        hi_nx = '0;
        lo_nx = '0;
        for (int k = 0; k < CH; k++) begin
            run[k]   = (cmp[k] != cmp_q[k]) ? '0 : stab[k];
            hi_nx[k] = enable && cmp[k] && (run[k] >= dt_act);
            lo_nx[k] = enable && !cmp[k] && (run[k] >= dt_act);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dt_act <= '0;
            dt_stg <= '0;
            cmp_q  <= '0;
            for (int k = 0; k < CH; k++)
                stab[k] <= '0;
        end else begin
            if (load_req)
                dt_stg <= dead_time;
            if (apply)
                dt_act <= dt_stg;
            cmp_q <= cmp;
            for (int k = 0; k < CH; k++)
                stab[k] <= (run[k] == DT_MAX) ? run[k] : run[k] + DT_ONE;
        end
    end
`else
    logic unused_dead_time;
    assign unused_dead_time = ^dead_time;
    assign hi_nx = enable ? cmp : '0;
    assign lo_nx = enable ? ~cmp : '0;
`endif

endmodule
